// File: rtl/lc3_dmem_access_ctrl.sv
// LC3 data-memory access sequencer: direct and indirect loads/stores onto a
// single-port dmem with level commands, completion pulses and a phase timeout.
module lc3_dmem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_complete
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // PTR   | indirect op: pointer read outstanding
  // ACC   | data read/write outstanding
  // RSP   | response held until rsp_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PTR  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [1:0]        state;
  logic              op_wr;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0]     timer;
  logic              expired;

  assign expired = (TIMEOUT != 0) && (timer == TMAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      dmem_rd   <= 1'b0;
      dmem_wr   <= 1'b0;
      dmem_addr <= '0;
      dmem_din  <= '0;
      timer     <= '0;
      op_wr     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_wr     <= req_op[0];
            wdata_q   <= req_wdata;
            dmem_addr <= req_addr;
            dmem_din  <= req_wdata;
            timer     <= '0;
            if (req_op[1]) begin
              state   <= S_PTR;
              dmem_rd <= 1'b1;
            end else begin
              state   <= S_ACC;
              dmem_rd <= ~req_op[0];
              dmem_wr <= req_op[0];
            end
          end
        end
        S_PTR: begin
          // A completion in the last allowed cycle takes priority over the timeout.
          if (dmem_complete) begin
            state     <= S_ACC;
            dmem_addr <= dmem_dout[ADDR_W-1:0];
            dmem_rd   <= ~op_wr;
            dmem_wr   <= op_wr;
            timer     <= '0;
          end else if (expired) begin
            state     <= S_RSP;
            dmem_rd   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ACC: begin
          if (dmem_complete) begin
            state     <= S_RSP;
            dmem_rd   <= 1'b0;
            dmem_wr   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= op_wr ? wdata_q : dmem_dout;
          end else if (expired) begin
            state     <= S_RSP;
            dmem_rd   <= 1'b0;
            dmem_wr   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_dmem_access_ctrl.sv
// Randomized bench for lc3_dmem_access_ctrl: each transaction is expanded into a
// cycle timeline from its memory latencies, and DUT outputs are checked against it.
module tb_lc3_dmem_access_ctrl;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data, dmem_addr, dmem_din, dmem_dout;
  logic        dmem_rd, dmem_wr, dmem_complete;

  lc3_dmem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_dout(dmem_dout), .dmem_complete(dmem_complete)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, written by the stimulus side.
  logic        chk_en = 1'b0;
  logic        e_req_ready, e_rd, e_wr, e_rsp_valid, e_rsp_err;
  logic [15:0] e_addr, e_din, e_rsp_data;
  int          tcur;
  logic        prev_valid = 1'b0;
  int          rise_t;
  logic [15:0] rise_data;
  logic        rise_err;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("req_ready", req_ready, e_req_ready);
      chk("dmem_rd", dmem_rd, e_rd);
      chk("dmem_wr", dmem_wr, e_wr);
      chk("rd_wr_exclusive", dmem_rd & dmem_wr, 1'b0);
      if (e_rd || e_wr) chk("dmem_addr", dmem_addr, e_addr);
      if (e_wr) chk("dmem_din", dmem_din, e_din);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        chk("rsp_data", rsp_data, e_rsp_data);
        chk("rsp_err", rsp_err, e_rsp_err);
      end
      if (rsp_valid && !prev_valid) begin
        rise_t    = tcur;
        rise_data = rsp_data;
        rise_err  = rsp_err;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic set_idle_exp();
    e_req_ready = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
    e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_addr = '0; e_din = '0; e_rsp_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      dmem_complete = 1'($urandom);
      dmem_dout = 16'($urandom);
      rsp_ready = 1'($urandom);
      tcur = -1;
      set_idle_exp();
    end
  endtask

  // Memory latency L: completion on the L-th command cycle; L > TO means no completion.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] ptrv, input logic [15:0] rdv,
                         input int l0, input int l1, input int hold);
    int lat[2];
    int st[2], n[2];
    bit ok[2];
    int np, s, r, last;
    bit err;
    lat[0] = l0; lat[1] = l1;
    np = op[1] ? 2 : 1;
    s = 1; err = 0;
    for (int p = 0; p < 2; p++) begin st[p] = 0; n[p] = 0; ok[p] = 0; end
    for (int p = 0; p < np; p++) begin
      if (!err) begin
        st[p] = s;
        if (lat[p] <= TO) begin n[p] = lat[p]; ok[p] = 1; s += lat[p]; end
        else begin n[p] = TO; ok[p] = 0; err = 1; s += TO; end
      end
    end
    r = s;
    last = r + hold;
    for (int t = 0; t <= last; t++) begin
      @(posedge clock); #1;
      tcur = t;
      req_valid = (t == 0);
      if (t == 0) begin req_op = op; req_addr = addr; req_wdata = wdata; end
      else begin req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom); end
      dmem_complete = (t == 0) ? 1'($urandom) : 1'b0;
      dmem_dout = 16'($urandom);
      rsp_ready = 1'($urandom);
      e_req_ready = (t == 0); e_rd = 1'b0; e_wr = 1'b0;
      e_rsp_valid = 1'b0; e_rsp_err = 1'b0; e_addr = '0; e_din = wdata; e_rsp_data = '0;
      for (int p = 0; p < np; p++) begin
        if (n[p] > 0 && t >= st[p] && t < st[p] + n[p]) begin
          bit is_ptr;
          is_ptr = op[1] && (p == 0);
          e_rd = is_ptr || !op[0];
          e_wr = !is_ptr && op[0];
          e_addr = is_ptr ? addr : (op[1] ? ptrv : addr);
          if (ok[p] && t == st[p] + n[p] - 1) begin
            dmem_complete = 1'b1;
            dmem_dout = is_ptr ? ptrv : rdv;
          end
        end
      end
      if (t >= r) begin
        e_rsp_valid = 1'b1;
        e_rsp_err = err;
        e_rsp_data = err ? 16'h0 : (op[0] ? wdata : rdv);
        rsp_ready = (t == last);
        dmem_complete = 1'($urandom);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; dmem_dout = '0; dmem_complete = 1'b0;
    tcur = -1;
    set_idle_exp();
    repeat (2) @(negedge clock);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 16'h0);
    chk("reset_dmem_addr", dmem_addr, 16'h0);
    chk("reset_dmem_din", dmem_din, 16'h0);
    chk("reset_cmd", {dmem_rd, dmem_wr}, 2'b00);
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    run_txn(2'b00, 16'h3000, 16'h0, 16'h0, 16'hBEEF, 1, 1, 0);
    idle(1);
    chk("read_latency", 32'(rise_t), 32'd2);
    chk("read_data", rise_data, 16'hBEEF);
    chk("read_err", rise_err, 1'b0);

    run_txn(2'b01, 16'h3010, 16'h1234, 16'h0, 16'h0, 3, 1, 0);
    idle(1);
    chk("write_latency", 32'(rise_t), 32'd4);
    chk("write_data", rise_data, 16'h1234);

    run_txn(2'b10, 16'h4000, 16'h0, 16'h5000, 16'h00AA, 1, 1, 0);
    idle(1);
    chk("ldi_latency", 32'(rise_t), 32'd3);
    chk("ldi_data", rise_data, 16'h00AA);

    run_txn(2'b11, 16'h4000, 16'h7777, 16'h5000, 16'h0, 1, 2, 0);
    idle(1);
    chk("sti_data", rise_data, 16'h7777);

    run_txn(2'b00, 16'h3020, 16'h0, 16'h0, 16'h5A5A, TO + 1, 1, 0);
    idle(1);
    chk("timeout_latency", 32'(rise_t), 32'd9);
    chk("timeout_err", rise_err, 1'b1);
    chk("timeout_data", rise_data, 16'h0);

    run_txn(2'b00, 16'h3030, 16'h0, 16'h0, 16'hC3C3, TO, 1, 0);
    idle(1);
    chk("last_cycle_err", rise_err, 1'b0);
    chk("last_cycle_data", rise_data, 16'hC3C3);

    run_txn(2'b10, 16'h4100, 16'h0, 16'h6000, 16'h0, TO + 1, 1, 0);
    run_txn(2'b00, 16'h3040, 16'h0, 16'h0, 16'h0F0F, 2, 1, 5);
    idle(3);

    // Reset asserted while the pointer read is outstanding.
    chk_en = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h4200; dmem_complete = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("ptr_wait_rd", dmem_rd, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rd", dmem_rd, 1'b0);
    chk("async_rst_ready", req_ready, 1'b1);
    chk("async_rst_valid", rsp_valid, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    prev_valid = 1'b0;
    chk_en = 1'b1;
    set_idle_exp();
    idle(1);
    run_txn(2'b00, 16'h3050, 16'h0, 16'h0, 16'h1111, 1, 1, 0);
    idle(1);
    chk("post_reset_data", rise_data, 16'h1111);

    for (int i = 0; i < 200; i++) begin
      run_txn(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(1, TO + 2)), int'($urandom_range(1, TO + 2)),
              int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);
    chk_en = 1'b0;
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
